// File: rtl/aes_gf_pkg.sv
// aes_gf_pkg: shared GF(2^4) arithmetic and constants for the composite-field
// AES S-box.
//
// GF(16) uses the polynomial w^4 + w + 1. GF(256) is built over it with
// x^2 + x + lambda, with lambda = w^3 + w^2. A composite byte is {p, q}, meaning
// p*x + q, with p in bits [7:4].
//
// ISO maps an AES byte (polynomial 0x11B) into the composite domain.
// ISO_INV maps a composite byte back to an AES byte.
// Both matrices are stored column-wise: entry [j] is the image of input bit j.
// They are derived at elaboration time from roots of the two field polynomials.
// This guarantees that they are a true field isomorphism pair.
package aes_gf_pkg;

  localparam logic [3:0] GF16_LAMBDA  = 4'hC;
  localparam logic [7:0] AFFINE_FWD_C = 8'h63;
  localparam logic [7:0] AFFINE_INV_C = 8'h05;

  typedef logic [7:0][7:0] bitmat8_t;

  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] acc;
    logic [3:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[2:0], 1'b0} ^ (sh[3] ? 4'h3 : 4'h0);
    end
    return acc;
  endfunction

  function automatic logic [3:0] gf16_sq(input logic [3:0] a);
    return gf16_mul(a, a);
  endfunction

  // a^14 = a^-1 for nonzero a. It yields 0 for a = 0.
  function automatic logic [3:0] gf16_inv(input logic [3:0] a);
    logic [3:0] a2, a4, a8;
    a2 = gf16_sq(a);
    a4 = gf16_sq(a2);
    a8 = gf16_sq(a4);
    return gf16_mul(gf16_mul(a2, a4), a8);
  endfunction

  function automatic logic [7:0] affine_fwd(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
           ^ AFFINE_FWD_C;
  endfunction

  function automatic logic [7:0] affine_inv(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ AFFINE_INV_C;
  endfunction

  function automatic logic [7:0] bitmat_apply(input bitmat8_t m, input logic [7:0] v);
    logic [7:0] y;
    y = '0;
    for (int j = 0; j < 8; j++) begin
      if (v[j]) y = y ^ m[j];
    end
    return y;
  endfunction

  // AES-field multiply. It is used only to derive the isomorphism constants.
  function automatic logic [7:0] gf256_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1B : 8'h00);
    end
    return acc;
  endfunction

  function automatic bitmat8_t calc_iso_inv();
    bitmat8_t   m;
    logic [7:0] w, x, lam, pw, c8, c2;
    logic       found_w, found_x;
    m       = '0;
    w       = 8'h00;
    x       = 8'h00;
    found_w = 1'b0;
    found_x = 1'b0;
    // W: a root of w^4 + w + 1 inside GF(256).
    for (int c = 2; c < 256; c++) begin
      c8 = 8'(c);
      c2 = gf256_mul(c8, c8);
      if (!found_w && ((gf256_mul(c2, c2) ^ c8) == 8'h01)) begin
        w       = c8;
        found_w = 1'b1;
      end
    end
    lam = gf256_mul(gf256_mul(w, w), w) ^ gf256_mul(w, w);
    // X: a root of x^2 + x + lambda.
    for (int c = 2; c < 256; c++) begin
      c8 = 8'(c);
      if (!found_x && ((gf256_mul(c8, c8) ^ c8) == lam)) begin
        x       = c8;
        found_x = 1'b1;
      end
    end
    pw = 8'h01;
    for (int i = 0; i < 4; i++) begin
      m[i]     = pw;
      m[4 + i] = gf256_mul(pw, x);
      pw       = gf256_mul(pw, w);
    end
    return m;
  endfunction

  function automatic bitmat8_t calc_iso(input bitmat8_t minv);
    bitmat8_t m;
    m = '0;
    for (int j = 0; j < 8; j++) begin
      for (int c = 0; c < 256; c++) begin
        if (bitmat_apply(minv, 8'(c)) == (8'h01 << j)) m[j] = 8'(c);
      end
    end
    return m;
  endfunction

  localparam bitmat8_t ISO_INV = calc_iso_inv();
  localparam bitmat8_t ISO     = calc_iso(ISO_INV);

endpackage

// File: rtl/aes_sbox_lane.sv
// aes_sbox_lane: one byte lane of the composite-field S-box.
// It has no registers. It is split into three combinational segments, and the
// parent places a pipeline register after each segment.
//
//   seg1_a/seg1_inv -> seg1_y : optional inverse affine, then map into GF(16)^2
//   seg2_a          -> seg2_y : GF(16)^2 inversion
//   seg3_a/seg3_inv -> seg3_y : map back to GF(256), forward affine unless inv
//
// Macro AES_SBOX_INV_EN: when defined, the inv inputs select InvSubBytes.
// When undefined, the inv inputs are ignored and only the forward S-box exists.
module aes_sbox_lane
  import aes_gf_pkg::*;
(
  input  logic [7:0] seg1_a,
  input  logic       seg1_inv,
  output logic [7:0] seg1_y,
  input  logic [7:0] seg2_a,
  output logic [7:0] seg2_y,
  input  logic [7:0] seg3_a,
  input  logic       seg3_inv,
  output logic [7:0] seg3_y
);

  logic [7:0] s1_pre;
  logic [7:0] s3_byte;
  logic [3:0] p, q, d, dinv;

`ifdef AES_SBOX_INV_EN
  assign s1_pre = seg1_inv ? affine_inv(seg1_a) : seg1_a;
`else
  logic unused_inv;
  assign unused_inv = seg1_inv ^ seg3_inv;
  assign s1_pre     = seg1_a;
`endif

  assign seg1_y = bitmat_apply(ISO, s1_pre);

  // (p*x + q)^-1 = (p*d^-1)*x + (p+q)*d^-1, with d = lambda*p^2 + p*q + q^2.
  assign p      = seg2_a[7:4];
  assign q      = seg2_a[3:0];
  assign d      = gf16_mul(GF16_LAMBDA, gf16_sq(p)) ^ gf16_mul(p, q) ^ gf16_sq(q);
  assign dinv   = gf16_inv(d);
  assign seg2_y = {gf16_mul(p, dinv), gf16_mul(p ^ q, dinv)};

  assign s3_byte = bitmat_apply(ISO_INV, seg3_a);

`ifdef AES_SBOX_INV_EN
  assign seg3_y = seg3_inv ? s3_byte : affine_fwd(s3_byte);
`else
  assign seg3_y = affine_fwd(s3_byte);
`endif

endmodule

// File: rtl/aes_sbox_pipe.sv
// aes_sbox_pipe: elastic, LANES-wide, 3- or 4-stage AES S-box pipeline.
//
// Ports:
//   clk, rst             clock (rising edge); asynchronous active-high reset
//   in_valid/in_ready    input handshake; in_ready never depends on in_valid
//   in_inv               0 = SubBytes, 1 = InvSubBytes (applies to the whole beat)
//   in_data[8*LANES]     input bytes; lane i is bits [8i+7:8i]
//   out_valid/out_ready  output handshake; the output holds while stalled
//   out_data[8*LANES]    substituted bytes, in the same lane order as the input
//
// Parameters: LANES (1..16) and OUT_REG (1 adds an output register stage).
// Macro AES_SBOX_INV_EN: when defined, in_inv is honoured.
// When undefined, in_inv is ignored and no inv flops are built.
//
// Each stage k loads when it is empty or when the stage after it loads.
// A full pipe therefore advances in a single edge when the output is popped.
module aes_sbox_pipe
  import aes_gf_pkg::*;
#(
  parameter int unsigned LANES   = 4,
  parameter int unsigned OUT_REG = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_inv,
  input  logic [8*LANES-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data
);

  localparam int unsigned W = 8 * LANES;

  logic         v1_q, v2_q, v3_q;
  logic [W-1:0] d1_q, d2_q, d3_q;
  logic [W-1:0] seg1_y, seg2_y, seg3_y;
  logic         load1, load2, load3, load_after3;
  logic         seg1_inv, seg3_inv;

  assign load3    = !v3_q | load_after3;
  assign load2    = !v2_q | load3;
  assign load1    = !v1_q | load2;
  assign in_ready = load1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      d1_q <= '0;
      d2_q <= '0;
      d3_q <= '0;
    end else begin
      if (load1) begin
        v1_q <= in_valid;
        if (in_valid) d1_q <= seg1_y;
      end
      if (load2) begin
        v2_q <= v1_q;
        if (v1_q) d2_q <= seg2_y;
      end
      if (load3) begin
        v3_q <= v2_q;
        if (v2_q) d3_q <= seg3_y;
      end
    end
  end

`ifdef AES_SBOX_INV_EN
  // The direction bit travels with its beat. Stage 3 holds the finished byte,
  // so no flop is needed past stage 2.
  logic inv1_q, inv2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inv1_q <= 1'b0;
      inv2_q <= 1'b0;
    end else begin
      if (load1 && in_valid) inv1_q <= in_inv;
      if (load2 && v1_q)     inv2_q <= inv1_q;
    end
  end

  assign seg1_inv = in_inv;
  assign seg3_inv = inv2_q;
`else
  logic unused_in_inv;
  assign unused_in_inv = in_inv;
  assign seg1_inv      = 1'b0;
  assign seg3_inv      = 1'b0;
`endif

  if (OUT_REG != 0) begin : g_out_reg
    logic         v4_q;
    logic [W-1:0] d4_q;
    logic         load4;

    assign load4       = !v4_q | out_ready;
    assign load_after3 = load4;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v4_q <= 1'b0;
        d4_q <= '0;
      end else if (load4) begin
        v4_q <= v3_q;
        if (v3_q) d4_q <= d3_q;
      end
    end

    assign out_valid = v4_q;
    assign out_data  = d4_q;
  end else begin : g_no_out_reg
    assign load_after3 = out_ready;
    assign out_valid   = v3_q;
    assign out_data    = d3_q;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    aes_sbox_lane u_lane (
      .seg1_a   (in_data[8*i +: 8]),
      .seg1_inv (seg1_inv),
      .seg1_y   (seg1_y[8*i +: 8]),
      .seg2_a   (d1_q[8*i +: 8]),
      .seg2_y   (seg2_y[8*i +: 8]),
      .seg3_a   (d2_q[8*i +: 8]),
      .seg3_inv (seg3_inv),
      .seg3_y   (seg3_y[8*i +: 8])
    );
  end

endmodule

// File: tb/tb_aes_sbox_pipe.sv
// Testbench for aes_sbox_pipe.
// Stimulus pushes expected beats into a queue, and a monitor pops and compares
// them. Expected bytes come from a GF(256) reference model: x^254 inversion plus
// the FIPS-197 bitwise affine rule. The inverse table is built by inverting the
// forward table.
module tb_aes_sbox_pipe;

  localparam int unsigned LANES   = 4;
  localparam int unsigned OUT_REG = 1;
  localparam int unsigned LAT     = 3 + OUT_REG;
  localparam int unsigned W       = 8 * LANES;
`ifdef AES_SBOX_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         in_inv;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  typedef struct {
    logic [W-1:0] data;
    int           acc_cyc;
    bit           lat_chk;
    bit           gap_chk;
  } exp_t;

  exp_t       exp_q[$];
  int         n_vec   = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  bit         bp_rand = 1'b0;
  logic [7:0] sbox_t  [256];
  logic [7:0] isbox_t [256];

  aes_sbox_pipe #(
    .LANES   (LANES),
    .OUT_REG (OUT_REG)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inv    (in_inv),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc, sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1B : 8'h00);
    end
    return acc;
  endfunction

  function automatic logic [7:0] ref_inv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = ref_mul(r, a);
    return r;
  endfunction

  function automatic logic [7:0] ref_affine(input logic [7:0] b);
    logic [7:0] r, c;
    c = 8'h63;
    for (int i = 0; i < 8; i++)
      r[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8] ^ c[i];
    return r;
  endfunction

  function automatic logic [W-1:0] model_beat(input logic [W-1:0] d, input logic inv);
    logic [W-1:0] r;
    for (int i = 0; i < LANES; i++)
      r[8*i +: 8] = (inv && INV_EN) ? isbox_t[d[8*i +: 8]] : sbox_t[d[8*i +: 8]];
    return r;
  endfunction

  task automatic check_v(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic check_i(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Must be called at a falling edge. It returns at a falling edge after the beat was accepted.
  task automatic send(input logic [W-1:0] data, input logic inv, input logic [W-1:0] exp_data,
                      input bit lat_chk, input bit gap_chk);
    exp_t e;
    bit   done;
    int   tries;
    in_valid = 1'b1;
    in_data  = data;
    in_inv   = inv;
    done     = 1'b0;
    tries    = 0;
    while (!done) begin
      #4;
      if (in_ready) begin
        e.data    = exp_data;
        e.acc_cyc = cyc;
        e.lat_chk = lat_chk;
        e.gap_chk = gap_chk;
        exp_q.push_back(e);
        done = 1'b1;
      end else if (tries == 50) begin
        n_vec++;
        n_fail++;
        $display("FAIL send_timeout: in_ready stayed 0, expected 1");
        done = 1'b1;
      end
      tries++;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check_i({name, "_drained"}, exp_q.size(), 0);
  endtask

  // Monitor: samples just before each rising edge.
  initial begin : monitor
    logic [W-1:0] prev_data;
    bit           prev_stall;
    int           last_pop;
    exp_t         e;
    prev_stall = 1'b0;
    prev_data  = '0;
    last_pop   = -10;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check_i("hold_valid", int'(out_valid), 1);
          check_v("hold_data", out_data, prev_data);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_output: got %h, expected no beat", out_data);
          end else begin
            e = exp_q.pop_front();
            check_v("out_data", out_data, e.data);
            if (e.lat_chk) check_i("latency", cyc - e.acc_cyc, LAT);
            if (e.gap_chk) check_i("no_bubble", cyc - last_pop, 1);
          end
          last_pop = cyc;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end
    end
  end

  // Random backpressure, enabled only during the random phase.
  initial begin
    forever begin
      @(negedge clk);
      if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time expired, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] d;
    logic [W-1:0] e0;
    logic         iv;
    int           n_acc;

    for (int i = 0; i < 256; i++) sbox_t[i] = ref_affine(ref_inv(8'(i)));
    for (int i = 0; i < 256; i++) isbox_t[sbox_t[i]] = 8'(i);

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_inv    = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    // Reset state.
    #12;
    check_i("rst_out_valid", int'(out_valid), 0);
    check_v("rst_out_data", out_data, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check_i("rst_in_ready", int'(in_ready), 1);
    check_i("rst_out_valid_after", int'(out_valid), 0);
    @(negedge clk);

    // Directed forward vector with latency check.
    send(32'h53010000, 1'b0, 32'hED7C6363, 1'b1, 1'b0);
    drain("fwd_vec");

    // Inverse round trip.
    e0 = INV_EN ? 32'h53010000 : model_beat(32'hED7C6363, 1'b0);
    send(32'hED7C6363, 1'b1, e0, 1'b1, 1'b0);
    drain("inv_vec");

    // All 256 bytes in both directions, back to back.
    for (int k = 0; k < 64; k++) begin
      d = {8'(4*k + 3), 8'(4*k + 2), 8'(4*k + 1), 8'(4*k)};
      send(d, 1'b0, model_beat(d, 1'b0), 1'b0, k != 0);
    end
    for (int k = 0; k < 64; k++) begin
      d = {8'(4*k + 3), 8'(4*k + 2), 8'(4*k + 1), 8'(4*k)};
      send(d, 1'b1, model_beat(d, 1'b1), 1'b0, 1'b1);
    end
    drain("sweep");

    // Interleaved directions on 0x00.
    for (int k = 0; k < 8; k++) begin
      iv = 1'(k % 2);
      e0 = (iv && INV_EN) ? 32'h52525252 : 32'h63636363;
      send('0, iv, e0, 1'b0, k != 0);
    end
    drain("interleave");

    // Backpressure: fill the pipe, then check capacity and output stability.
    out_ready = 1'b0;
    n_acc     = 0;
    for (int k = 0; k < 12; k++) begin
      d        = W'($urandom);
      iv       = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      in_data  = d;
      in_inv   = iv;
      #4;
      if (in_ready) begin
        exp_q.push_back('{data: model_beat(d, iv), acc_cyc: cyc, lat_chk: 1'b0, gap_chk: 1'b0});
        n_acc++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check_i("bp_capacity", n_acc, LAT);
    #1;
    check_i("bp_in_ready_low", int'(in_ready), 0);
    @(negedge clk);
    out_ready = 1'b1;
    drain("bp");

    // Reset mid-stream: one beat held at the output and a second beat behind it.
    out_ready = 1'b0;
    send(32'h00112233, 1'b0, model_beat(32'h00112233, 1'b0), 1'b0, 1'b0);
    repeat (LAT - 1) @(negedge clk);
    send(32'h44556677, 1'b0, model_beat(32'h44556677, 1'b0), 1'b0, 1'b0);
    #1;
    check_i("pre_rst_out_valid", int'(out_valid), 1);
    #1;
    rst = 1'b1;
    #1;
    check_i("midrst_out_valid", int'(out_valid), 0);
    check_i("midrst_in_ready", int'(in_ready), 1);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    send(32'hA5C3F00F, 1'b0, model_beat(32'hA5C3F00F, 1'b0), 1'b1, 1'b0);
    drain("post_rst");

    // Random traffic with random backpressure.
    bp_rand = 1'b1;
    for (int k = 0; k < 300; k++) begin
      d  = W'($urandom);
      iv = 1'($urandom_range(0, 1));
      send(d, iv, model_beat(d, iv), 1'b0, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    bp_rand   = 1'b0;
    out_ready = 1'b1;
    drain("random");

    repeat (LAT + 2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
